// File: rtl/vga_cmd_dma.sv
// vga_cmd_dma: register-programmed DMA that streams 32-bit VGA command words
// from memory into the VGA command AXI-Stream port through a prefetch FIFO.
module vga_cmd_dma #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        reg_sel_i,
    input  logic        reg_we_i,
    input  logic [1:0]  reg_addr_i,
    input  logic [31:0] reg_data_i,
    output logic [31:0] reg_data_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        cmd_axis_tvalid_o,
    input  logic        cmd_axis_tready_i,
    output logic [31:0] cmd_axis_tdata_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t           state;
    logic [31:0]      src_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_s;
    logic             aborted_s;
    logic             start_err_s;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] req_left_q;
    logic [CNT_W-1:0] rem_q;
    logic             ret_vld_p1;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] fifo_cnt;

    logic             ctrl_wr;
    logic             start_req;
    logic             abort_req;
    logic             ack_ok;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] rem_next;

    assign ctrl_wr   = reg_sel_i && reg_we_i && (reg_addr_i == 2'd2);
    assign start_req = ctrl_wr && reg_data_i[0] && !reg_data_i[1];
    assign abort_req = ctrl_wr && reg_data_i[1];

    // Slots already spoken for: words held plus a word returning this cycle.
    assign occ        = fifo_cnt + OCC_W'(ret_vld_p1);
    assign mem_req_o  = (state == FETCH) && (req_left_q != '0) && (occ < OCC_W'(FIFO_DEPTH));
    assign mem_addr_o = addr_q;
    assign ack_ok     = mem_req_o && mem_ack_i;

    assign cmd_axis_tvalid_o = (fifo_cnt != '0);
    assign cmd_axis_tdata_o  = cmd_axis_tvalid_o ? fifo_mem[rd_ptr] : '0;
    assign pop               = cmd_axis_tvalid_o && cmd_axis_tready_i;
    assign rem_next          = rem_q - CNT_W'(pop);
    assign busy_o            = (state != IDLE);

    // Register read mux; remaining count shows the value before any pop this cycle.
    always_comb begin
        reg_data_o = '0;
        case (reg_addr_i)
            2'd0:    reg_data_o = src_q;
            2'd1:    reg_data_o[CNT_W-1:0] = cnt_q;
            2'd2:    reg_data_o = {16'(rem_q), 12'd0, start_err_s, aborted_s, done_s, busy_o};
            default: reg_data_o = '0;
        endcase
    end

    // FIFO storage carries data only, so it is written without reset.
    always_ff @(posedge clk) begin
        if (ret_vld_p1)
            fifo_mem[wr_ptr] <= mem_data_i;
    end

    // Control FSM: registers, fetch sequencing, FIFO pointers and completion/abort.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            src_q       <= '0;
            cnt_q       <= '0;
            done_s      <= 1'b0;
            aborted_s   <= 1'b0;
            start_err_s <= 1'b0;
            addr_q      <= '0;
            req_left_q  <= '0;
            rem_q       <= '0;
            ret_vld_p1  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            ret_vld_p1 <= ack_ok;

            if (reg_sel_i && reg_we_i && reg_addr_i == 2'd0)
                src_q <= {reg_data_i[31:2], 2'b00};
            if (reg_sel_i && reg_we_i && reg_addr_i == 2'd1)
                cnt_q <= reg_data_i[CNT_W-1:0];

            if (ret_vld_p1)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + OCC_W'(ret_vld_p1) - OCC_W'(pop);

            case (state)
                IDLE: begin
                    if (start_req) begin
                        done_s      <= 1'b0;
                        aborted_s   <= 1'b0;
                        start_err_s <= 1'b0;
                        addr_q      <= src_q;
                        req_left_q  <= cnt_q;
                        rem_q       <= cnt_q;
                        // An empty block skips fetching and completes from DRAIN.
                        state       <= (cnt_q == '0) ? DRAIN : FETCH;
                    end
                end
                default: begin
                    if (start_req)
                        start_err_s <= 1'b1;
                    if (ack_ok) begin
                        addr_q     <= addr_q + 32'd4;
                        req_left_q <= req_left_q - CNT_W'(1);
                        if (req_left_q == CNT_W'(1))
                            state <= DRAIN;
                    end
                    rem_q <= rem_next;
                    if (rem_next == '0) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                        done_s <= 1'b1;
                    end
                    // Abort overrides everything: drop the pending return and flush.
                    if (abort_req) begin
                        state      <= IDLE;
                        done_o     <= 1'b0;
                        done_s     <= 1'b0;
                        aborted_s  <= 1'b1;
                        ret_vld_p1 <= 1'b0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        fifo_cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_cmd_dma.sv
// tb_vga_cmd_dma: directed bench for vga_cmd_dma with a simple memory model
// and an always-recording sink/request monitor.
module tb_vga_cmd_dma;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        reg_sel_i;
    logic        reg_we_i;
    logic [1:0]  reg_addr_i;
    logic [31:0] reg_data_i;
    logic [31:0] reg_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        cmd_axis_tvalid_o;
    logic        cmd_axis_tready_i;
    logic [31:0] cmd_axis_tdata_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic ack_en;

    logic [31:0] ack_q[$];
    logic [31:0] pop_q[$];
    int done_cnt, busy_cnt, req_cnt, tvalid_cnt, done_cyc, first_req, first_tv, start_cyc;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    vga_cmd_dma #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset_i(reset_i),
        .reg_sel_i(reg_sel_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i),
        .cmd_axis_tvalid_o(cmd_axis_tvalid_o), .cmd_axis_tready_i(cmd_axis_tready_i),
        .cmd_axis_tdata_o(cmd_axis_tdata_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    // Memory: accepts when enabled, returns data one cycle after the ack.
    assign mem_ack_i = mem_req_o && ack_en;
    always @(posedge clk)
        mem_data_i <= (mem_req_o && mem_ack_i) ? mdata(mem_addr_o) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor at the falling edge, when every input and output is settled.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (mem_req_o && mem_ack_i) ack_q.push_back(mem_addr_o);
            if (cmd_axis_tvalid_o && cmd_axis_tready_i) pop_q.push_back(cmd_axis_tdata_o);
            if (done_o) begin done_cnt++; done_cyc = cyc; end
            if (busy_o) busy_cnt++;
            if (mem_req_o) begin req_cnt++; if (first_req < 0) first_req = cyc; end
            if (cmd_axis_tvalid_o) begin tvalid_cnt++; if (first_tv < 0) first_tv = cyc; end
            if (prev_stall && cmd_axis_tvalid_o) check("tdata_stable", cmd_axis_tdata_o, prev_data);
            prev_stall = cmd_axis_tvalid_o && !cmd_axis_tready_i;
            prev_data  = cmd_axis_tdata_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        reg_sel_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_data_i = d;
        tick();
        reg_sel_i = 1'b0; reg_we_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        reg_addr_i = a;
        #1;
        d = reg_data_o;
    endtask

    task automatic clear_mon();
        ack_q.delete(); pop_q.delete();
        done_cnt = 0; busy_cnt = 0; req_cnt = 0; tvalid_cnt = 0;
        done_cyc = -1; first_req = -1; first_tv = -1;
    endtask

    task automatic start();
        start_cyc = cyc;
        reg_wr(2'd2, 32'h1);
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (busy_o && i < 300) begin tick(); i++; end
        check({name, "_timeout"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic check_stream(input string name, input logic [31:0] base, input int n);
        check({name, "_n_acks"}, ack_q.size(), n);
        check({name, "_n_pops"}, pop_q.size(), n);
        for (int i = 0; i < n && i < ack_q.size(); i++)
            check($sformatf("%s_addr%0d", name, i), ack_q[i], base + 32'(4 * i));
        for (int i = 0; i < n && i < pop_q.size(); i++)
            check($sformatf("%s_data%0d", name, i), pop_q[i], mdata(base + 32'(4 * i)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int snap_ack, snap_tv;

        reset_i = 1'b1; reg_sel_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = 2'd0;
        reg_data_i = '0; cmd_axis_tready_i = 1'b0; ack_en = 1'b1;
        clear_mon();
        repeat (3) tick();
        check("rst_req", {31'd0, mem_req_o}, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_tvalid", {31'd0, cmd_axis_tvalid_o}, 0);
        check("rst_tdata", cmd_axis_tdata_o, 0);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_done", {31'd0, done_o}, 0);
        reset_i = 1'b0;
        tick();

        // Register access table
        vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 2'd0, 32'h0000_1237, 32'h0};
        vecs[4]  = '{1'b0, 2'd0, 32'h0,        32'h0000_1234};
        vecs[5]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 32'h0,        32'hFFFF_FFFC};
        vecs[7]  = '{1'b1, 2'd1, 32'h0001_2345, 32'h0};
        vecs[8]  = '{1'b0, 2'd1, 32'h0,        32'h0000_2345};
        vecs[9]  = '{1'b1, 2'd2, 32'h0000_0002, 32'h0};
        vecs[10] = '{1'b0, 2'd2, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 2'd2, 32'h0000_0003, 32'h0};
        vecs[12] = '{1'b0, 2'd2, 32'h0,        32'h0};
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].we) reg_wr(vecs[i].addr, vecs[i].wdata);
            else begin
                reg_rd(vecs[i].addr, rd);
                check($sformatf("regvec%0d", i), rd, vecs[i].exp);
            end
        end

        // Basic 3-word transfer, sink always ready
        cmd_axis_tready_i = 1'b1;
        reg_wr(2'd0, 32'h100);
        reg_wr(2'd1, 32'd3);
        clear_mon();
        start();
        wait_idle("t1");
        repeat (3) tick();
        check_stream("t1", 32'h100, 3);
        check("t1_first_req_cyc", first_req, start_cyc + 1);
        check("t1_first_tvalid_cyc", first_tv, start_cyc + 3);
        check("t1_done_pulses", done_cnt, 1);
        reg_rd(2'd2, rd);
        check("t1_status", rd, 32'h0000_0002);

        // Sink stalled for 20 cycles: fetch stops at FIFO depth
        cmd_axis_tready_i = 1'b0;
        reg_wr(2'd1, 32'd6);
        clear_mon();
        start();
        repeat (20) tick();
        check("t2_acks_stalled", ack_q.size(), 4);
        check("t2_req_low_full", {31'd0, mem_req_o}, 0);
        check("t2_tvalid", {31'd0, cmd_axis_tvalid_o}, 1);
        check("t2_tdata_head", cmd_axis_tdata_o, 32'hA0);
        reg_rd(2'd2, rd);
        check("t2_status_stalled", rd, 32'h0006_0001);
        cmd_axis_tready_i = 1'b1;
        wait_idle("t2");
        repeat (3) tick();
        check_stream("t2", 32'h100, 6);
        check("t2_done_pulses", done_cnt, 1);

        // Empty block
        reg_wr(2'd1, 32'd0);
        clear_mon();
        start();
        wait_idle("t3");
        repeat (3) tick();
        check("t3_req_cnt", req_cnt, 0);
        check("t3_tvalid_cnt", tvalid_cnt, 0);
        check("t3_busy_cycles", busy_cnt, 1);
        check("t3_done_pulses", done_cnt, 1);
        check("t3_done_cyc", done_cyc, start_cyc + 2);
        reg_rd(2'd2, rd);
        check("t3_status", rd, 32'h0000_0002);

        // Abort after 4 pops, with an ack in the abort cycle
        reg_wr(2'd1, 32'd10);
        clear_mon();
        start();
        for (int i = 0; i < 100 && pop_q.size() < 4; i++) tick();
        check("t4_pops_before", pop_q.size(), 4);
        reg_sel_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 2'd2; reg_data_i = 32'h2;
        cmd_axis_tready_i = 1'b0;
        @(negedge clk);
        check("t4_ack_in_abort_cycle", {31'd0, mem_req_o && mem_ack_i}, 1);
        tick();
        reg_sel_i = 1'b0; reg_we_i = 1'b0;
        check("t4_req_after", {31'd0, mem_req_o}, 0);
        check("t4_tvalid_after", {31'd0, cmd_axis_tvalid_o}, 0);
        check("t4_busy_after", {31'd0, busy_o}, 0);
        snap_ack = ack_q.size();
        snap_tv = tvalid_cnt;
        repeat (20) tick();
        check("t4_no_more_acks", ack_q.size(), snap_ack);
        check("t4_no_more_tvalid", tvalid_cnt, snap_tv);
        check("t4_pops_total", pop_q.size(), 4);
        check("t4_pop3", pop_q[3], 32'hA3);
        check("t4_done_pulses", done_cnt, 0);
        reg_rd(2'd2, rd);
        check("t4_status_low", rd & 32'hF, 32'h4);

        // START while busy and SRC rewrite mid-transfer
        cmd_axis_tready_i = 1'b1;
        reg_wr(2'd0, 32'h300);
        reg_wr(2'd1, 32'd5);
        clear_mon();
        start();
        reg_wr(2'd2, 32'h1);
        reg_wr(2'd0, 32'h400);
        reg_rd(2'd2, rd);
        check("t5_status_busy_err", rd & 32'hF, 32'h9);
        wait_idle("t5a");
        repeat (3) tick();
        check_stream("t5a", 32'h300, 5);
        reg_rd(2'd2, rd);
        check("t5a_status", rd, 32'h0000_000A);
        clear_mon();
        start();
        wait_idle("t5b");
        repeat (3) tick();
        check_stream("t5b", 32'h400, 5);
        reg_rd(2'd2, rd);
        check("t5b_status", rd, 32'h0000_0002);

        // Asynchronous reset mid-FETCH with memory stalled, then address wrap
        ack_en = 1'b0;
        reg_wr(2'd0, 32'h500);
        reg_wr(2'd1, 32'd4);
        clear_mon();
        start();
        repeat (3) tick();
        check("t6_req_stalled", {31'd0, mem_req_o}, 1);
        check("t6_addr_stalled", mem_addr_o, 32'h500);
        #3;
        reset_i = 1'b1;
        #1;
        check("t6_rst_req", {31'd0, mem_req_o}, 0);
        check("t6_rst_addr", mem_addr_o, 0);
        check("t6_rst_busy", {31'd0, busy_o}, 0);
        check("t6_rst_tvalid", {31'd0, cmd_axis_tvalid_o}, 0);
        check("t6_rst_done", {31'd0, done_o}, 0);
        reg_rd(2'd0, rd);
        check("t6_rst_src", rd, 0);
        reg_rd(2'd2, rd);
        check("t6_rst_status", rd, 0);
        repeat (2) tick();
        reset_i = 1'b0;
        ack_en = 1'b1;
        tick();
        reg_wr(2'd0, 32'hFFFF_FFFC);
        reg_wr(2'd1, 32'd2);
        clear_mon();
        start();
        wait_idle("t6");
        repeat (3) tick();
        check_stream("t6", 32'hFFFF_FFFC, 2);
        check("t6_done_pulses", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_cmd_dma.md
Name: vga_cmd_dma

Overview:
DMA controller that streams a block of 32-bit VGA command words from SoC memory into the VGA command AXI-Stream port, so the CPU does not have to poll tready and write each word. Sits on the peripheral bus as a 3-register slave and acts as a memory-read master on the shared bram/spram port. Its output drives cmd_axis_* of the vga block.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries; power of 2, ≥2
CNT_W, 16, width of word-count register

Ports:
clk  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
reg_sel_i  in  1  register access strobe, one cycle per access
reg_we_i  in  1  1 = write, 0 = read
reg_addr_i  in  2  word index: 0 SRC, 1 COUNT, 2 CTRL/STATUS
reg_data_i  in  32  register write data
reg_data_o  out  32  register read data, combinational from reg_addr_i
mem_req_o  out  1  memory read request
mem_addr_o  out  32  byte address, word-aligned
mem_ack_i  in  1  request accepted this cycle
mem_data_i  in  32  read data, valid the cycle after mem_ack_i
cmd_axis_tvalid_o  out  1  command word valid
cmd_axis_tready_i  in  1  vga ready
cmd_axis_tdata_o  out  32  command word
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: all outputs 0. SRC=0, COUNT=0, FIFO empty, state IDLE, sticky bits clear.
- SRC write: bits[1:0] forced to 0. COUNT write: low CNT_W bits. Writes while busy update the register only; the active transfer uses shadow copies latched at start.
- CTRL write: bit0 START, bit1 ABORT; both set → ABORT wins. STATUS read: bit0 busy, bit1 done (sticky), bit2 aborted (sticky), bit3 start_err (sticky), [31:16] remaining words not yet accepted by the sink.
- START in IDLE: clears done/aborted/start_err, latches SRC/COUNT; busy_o=1 the next cycle. START while busy: ignored, start_err=1.
- COUNT=0 at START: no memory requests; busy_o pulses for 1 cycle, then done_o=1 and done=1.
- States: IDLE → FETCH (requests outstanding) → DRAIN (all words requested, waiting for FIFO to empty) → IDLE.
- Memory handshake: mem_req_o and mem_addr_o stay stable until mem_ack_i=1 sampled. A request is issued only when fifo_count + inflight < FIFO_DEPTH. Back-to-back requests are allowed: mem_addr_o advances by 4 in the ack cycle. Address wraps modulo 2^32.
- The word returned the cycle after an ack is written into the FIFO. The FIFO is not fall-through: tvalid rises no earlier than the cycle after the write.
- Minimum latency: START write at cycle N → mem_req_o at N+1; with ack at N+1 → tvalid at N+3.
- AXIS rules: tdata stable while tvalid && !tready. A word pops on tvalid && tready. The FIFO may be pushed and popped in the same cycle.
- Completion: the pop of the last word → done_o=1 the next cycle, sticky done=1, busy_o=0, state IDLE.
- ABORT while busy:
  - mem_req_o drops the next cycle.
  - A pending return after an ack is discarded.
  - FIFO is flushed; tvalid drops the next cycle even without tready (permitted only on abort).
  - aborted=1, no done_o. ABORT in IDLE has no effect.
- Reset mid-transfer: immediate return to reset state; in-flight data is discarded.
- Register read and a DMA pop in the same cycle: the remaining field shows the pre-pop value.

Test Plan:
- SRC=0x100, COUNT=3, memory returns 0xA0,0xA1,0xA2, tready=1 → mem_addr_o 0x100,0x104,0x108; tdata A0,A1,A2 in order; done_o single pulse; STATUS=0x0000_0002.
- Same transfer with tready=0 for 20 cycles → at most FIFO_DEPTH words fetched, mem_req_o low while full, tdata stable, no loss after tready=1.
- COUNT=0, START → no mem_req_o, done_o pulses within 2 cycles, no tvalid.
- COUNT=10, ABORT after 4 pops, including an ack in the abort cycle → mem_req_o=0 next cycle, tvalid=0 next cycle, STATUS bit2=1, done_o never asserts.
- START while busy, then SRC write mid-transfer → start_err=1; addresses continue from the original SRC; a later START uses the new SRC.
- Assert reset_i asynchronously mid-FETCH with stalled mem_ack_i → all outputs 0 immediately; a fresh START after release runs correctly; SRC=0xFFFF_FFFC with COUNT=2 wraps to 0x0.
